// File: rtl/c_add_nto1_pipe_pkg.sv
// c_add_nto1_pipe_pkg
//   Shared constant functions for the pipelined N-to-1 adder:
//   ceiling log2 and the stage-count / width derivations used by the top
//   and by the per-stage sizing in the generate loop.
//   No ports (package).
package c_add_nto1_pipe_pkg;

  // Smallest l such that 2**l >= n; clogb(1) = 0.
  function automatic int clogb(input int n);
    int l;
    l = 0;
    for (int p = 1; p < n; p = p * 2) l++;
    return l;
  endfunction

  function automatic int calc_num_stages(input int num_ports, input int levels_per_stage);
    int lv;
    int s;
    lv = clogb(num_ports);
    s  = (lv + levels_per_stage - 1) / levels_per_stage;
    return (s < 1) ? 1 : s;
  endfunction

  function automatic int calc_out_width(input int num_ports, input int width);
    return width + clogb(num_ports);
  endfunction

  // Tree levels evaluated by stage k: a full levels_per_stage slice, fewer in
  // the last stage, none when the tree has no levels at all.
  function automatic int stage_levels(input int levels, input int levels_per_stage, input int k);
    int r;
    r = levels - k * levels_per_stage;
    if (r > levels_per_stage) r = levels_per_stage;
    if (r < 0) r = 0;
    return r;
  endfunction

endpackage

// File: rtl/c_add_nto1_pipe_stage.sv
// c_add_nto1_pipe_stage
//   One pipeline stage of the adder tree: num_levels of combinational
//   pairwise additions on the upstream partial sums, then one register
//   boundary with its valid bit.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   up_valid, up_data   upstream valid bit and packed partial sums
//                       (in_count x in_width)
//   rdy                 this stage may load this cycle
//   valid, data         registered valid bit and packed partial sums
//                       ((in_count >> num_levels) x (in_width + num_levels))
module c_add_nto1_pipe_stage
  import c_add_nto1_pipe_pkg::*;
#(
  parameter int in_count   = 2,
  parameter int in_width   = 8,
  parameter int num_levels = 1,
  localparam int node_width = in_width + num_levels,
  localparam int out_count  = in_count >> num_levels
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            up_valid,
  input  logic [in_count*in_width-1:0]    up_data,
  input  logic                            rdy,
  output logic                            valid,
  output logic [out_count*node_width-1:0] data
);

  // Every node is kept at the final width; level l only ever needs
  // in_width + l bits, so the wider nodes never overflow.
  logic [node_width-1:0]           node [0:num_levels][0:in_count-1];
  logic [out_count*node_width-1:0] sum_flat;

  always_comb begin
    sum_flat = '0;
    for (int l = 0; l <= num_levels; l++)
      for (int i = 0; i < in_count; i++)
        node[l][i] = '0;
    for (int i = 0; i < in_count; i++)
      node[0][i] = node_width'(up_data[i*in_width +: in_width]);
    for (int l = 1; l <= num_levels; l++)
      for (int i = 0; i < (in_count >> l); i++)
        node[l][i] = node[l-1][2*i] + node[l-1][2*i+1];
    for (int i = 0; i < out_count; i++)
      sum_flat[i*node_width +: node_width] = node[num_levels][i];
  end

  // Data loads only when a real vector arrives, so bubbles leave stale data
  // untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (rdy) begin
      valid <= up_valid;
      if (up_valid) data <= sum_flat;
    end
  end

endmodule

// File: rtl/c_add_nto1_pipe.sv
// c_add_nto1_pipe
//   Pipelined, flow-controlled N-to-1 unsigned adder. Operands are
//   zero-padded to a power-of-two count and reduced by a binary tree with a
//   register every levels_per_stage levels; the last stage always registers.
//   Optional feature macro: C_ADD_NTO1_PIPE_MASK_EN adds port_mask, which
//   zeroes operand i before the tree when port_mask[i] = 0.
// Handshake: a transfer happens on a cycle where valid && ready are both 1;
//   valid never depends on ready, and the producer holds data while
//   valid && !ready. in_ready depends only on out_ready and stage valid bits.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid, in_ready  operand vector handshake
//   data_in             packed operands, port i at [i*width +: width]
//   port_mask           per-port include mask [0:num_ports-1] (macro only)
//   out_valid, out_ready  sum handshake
//   data_out            full-precision sum (width + clogb(num_ports) bits)
module c_add_nto1_pipe
  import c_add_nto1_pipe_pkg::*;
#(
  parameter int num_ports        = 4,
  parameter int width            = 8,
  parameter int levels_per_stage = 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [num_ports*width-1:0]                  data_in,
`ifdef C_ADD_NTO1_PIPE_MASK_EN
  input  logic [0:num_ports-1]                        port_mask,
`endif
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [calc_out_width(num_ports, width)-1:0] data_out
);

  localparam int levels     = clogb(num_ports);
  localparam int num_stages = calc_num_stages(num_ports, levels_per_stage);
  localparam int pad_ports  = 1 << levels;

  logic [pad_ports*width-1:0] padded;
  logic [num_stages-1:0]      stage_valid;
  logic [num_stages-1:0]      rdy;

  always_comb begin
    logic [width-1:0] op;
    padded = '0;
    for (int i = 0; i < num_ports; i++) begin
      op = data_in[i*width +: width];
`ifdef C_ADD_NTO1_PIPE_MASK_EN
      if (!port_mask[i]) op = '0;
`endif
      padded[i*width +: width] = op;
    end
  end

  genvar k;
  generate
    for (k = 0; k < num_stages; k++) begin : stg
      localparam int lk     = stage_levels(levels, levels_per_stage, k);
      localparam int in_cnt = pad_ports >> (k * levels_per_stage);
      localparam int in_w   = width + k * levels_per_stage;
      localparam int o_w    = (in_cnt >> lk) * (in_w + lk);

      logic               up_valid;
      logic [in_cnt*in_w-1:0] sin;
      logic [o_w-1:0]     sdata;
      logic               svalid;

      if (k == 0) begin : g_first
        assign up_valid = in_valid;
        assign sin      = padded;
      end else begin : g_chain
        assign up_valid = stage_valid[k-1];
        assign sin      = stg[k-1].sdata;
      end

      // Unrolled form of rdy[k] = !v[k] || rdy[k+1]: stage k may load when
      // the output is being taken or any stage from k downstream is empty.
      assign rdy[k] = out_ready | ~(&stage_valid[num_stages-1:k]);
      assign stage_valid[k] = svalid;

      c_add_nto1_pipe_stage #(
        .in_count  (in_cnt),
        .in_width  (in_w),
        .num_levels(lk)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .up_valid(up_valid),
        .up_data (sin),
        .rdy     (rdy[k]),
        .valid   (svalid),
        .data    (sdata)
      );
    end
  endgenerate

  assign in_ready  = rdy[0];
  assign out_valid = stage_valid[num_stages-1];
  assign data_out  = stg[num_stages-1].sdata;

endmodule

// File: tb/tb_c_add_nto1_pipe.sv
// tb_c_add_nto1_pipe
//   Bench for c_add_nto1_pipe. Main instance: 4 ports x 8 bits, one level
//   per stage. Second instance: 5 ports x 4 bits, two levels per stage.
//   Builds with or without C_ADD_NTO1_PIPE_MASK_EN.
module tb_c_add_nto1_pipe;

  localparam int NP = 4, W = 8, LPS = 1, OW = 10, NS = 2;
  localparam int NP5 = 5, W5 = 4, LPS5 = 2, OW5 = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid, in_ready, out_valid, out_ready;
  logic [NP*W-1:0]   data_in;
  logic [OW-1:0]     data_out;
  logic              in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [NP5*W5-1:0] data_in_b;
  logic [OW5-1:0]    data_out_b;
`ifdef C_ADD_NTO1_PIPE_MASK_EN
  logic [0:NP-1]     port_mask;
  logic [0:NP5-1]    port_mask_b;
`endif

  c_add_nto1_pipe #(.num_ports(NP), .width(W), .levels_per_stage(LPS)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
`ifdef C_ADD_NTO1_PIPE_MASK_EN
    .port_mask(port_mask),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  c_add_nto1_pipe #(.num_ports(NP5), .width(W5), .levels_per_stage(LPS5)) dut5 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .data_in(data_in_b),
`ifdef C_ADD_NTO1_PIPE_MASK_EN
    .port_mask(port_mask_b),
`endif
    .out_valid(out_valid_b), .out_ready(out_ready_b), .data_out(data_out_b)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [OW-1:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain sum of the enabled operands.
  function automatic int ref_sum(input logic [NP*W-1:0] d, input logic [NP-1:0] en);
    int s;
    s = 0;
    for (int i = 0; i < NP; i++)
      if (en[i]) s += int'(d[i*W +: W]);
    return s;
  endfunction

  function automatic logic [NP-1:0] cur_enables();
    logic [NP-1:0] en;
    en = '1;
`ifdef C_ADD_NTO1_PIPE_MASK_EN
    for (int i = 0; i < NP; i++) en[i] = port_mask[i];
`endif
    return en;
  endfunction

  // Called ~1 time unit after a falling edge with inputs driven: checks the
  // outputs against the model, records the transfers that the coming rising
  // edge performs, then advances to the next falling edge.
  task automatic step();
    check("in_ready", in_ready, (exp_q.size() < NS) || out_ready);
    if (out_valid) begin
      if (exp_q.size() == 0) check("out_valid_spurious", 1, 0);
      else begin
        check("data_out", data_out, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (in_valid && in_ready) exp_q.push_back(OW'(ref_sum(data_in, cur_enables())));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    #1;
    step();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [7:0] op[4];
    int         exp;
  } vec_t;

  typedef struct {
    logic [3:0] op[5];
    int         exp;
  } vec5_t;

  vec_t  tbl[6];
  vec5_t tbl5[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int accepts;

    tbl[0] = '{op: '{8'd255, 8'd255, 8'd255, 8'd255}, exp: 1020};
    tbl[1] = '{op: '{8'd1, 8'd2, 8'd3, 8'd4},         exp: 10};
    tbl[2] = '{op: '{8'd10, 8'd20, 8'd30, 8'd40},     exp: 100};
    tbl[3] = '{op: '{8'd0, 8'd0, 8'd0, 8'd1},         exp: 1};
    tbl[4] = '{op: '{8'd128, 8'd64, 8'd32, 8'd16},    exp: 240};
    tbl[5] = '{op: '{8'd0, 8'd0, 8'd0, 8'd0},         exp: 0};
    tbl5[0] = '{op: '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15}, exp: 75};
    tbl5[1] = '{op: '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5},      exp: 15};
    tbl5[2] = '{op: '{4'd0, 4'd0, 4'd0, 4'd0, 4'd9},      exp: 9};

    in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b1; data_in_b = '0;
`ifdef C_ADD_NTO1_PIPE_MASK_EN
    port_mask = '1; port_mask_b = '1;
`endif

    // reset state
    #1 reset = 1'b1;
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    @(negedge clk);

    // back-to-back table: latency 2, no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 6);
      if (i < 6) for (int p = 0; p < NP; p++) data_in[p*W +: W] = tbl[i].op[p];
      #1;
      check("tbl_out_valid", out_valid, (i >= 2));
      if (i >= 2) check("tbl_data_out", data_out, tbl[i-2].exp);
      step();
    end
    drain();

    // backpressure: out_ready low for 5 cycles with in_valid held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    accepts   = 0;
    for (int i = 0; i < 5; i++) begin
      for (int p = 0; p < NP; p++) data_in[p*W +: W] = 8'(10 * i + p + 1);
      #1;
      if (in_ready) accepts++;
      step();
    end
    check("bp_accepts", accepts, 2);
    #1;
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head", data_out, 10);
    step();
    drain();

    // reset one cycle after an accept
    in_valid = 1'b1;
    for (int p = 0; p < NP; p++) data_in[p*W +: W] = 8'(5 + p);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("postrst_no_output", out_valid, 0);
      step();
    end

    // 5-port, two levels per stage: latency 2, padding of the odd port
    for (int i = 0; i < 5; i++) begin
      in_valid_b = (i < 3);
      if (i < 3) for (int p = 0; p < NP5; p++) data_in_b[p*W5 +: W5] = tbl5[i].op[p];
      #1;
      check("p5_out_valid", out_valid_b, (i >= 2));
      if (i >= 2) check("p5_data_out", data_out_b, tbl5[i-2].exp);
      if (i < 3) check("p5_in_ready", in_ready_b, 1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid_b = 1'b0;

`ifdef C_ADD_NTO1_PIPE_MASK_EN
    // mask: only ports 1 and 3 contribute
    port_mask = 4'b0101;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int p = 0; p < NP; p++) data_in[p*W +: W] = tbl[2].op[p];
    tick();
    in_valid = 1'b0;
    port_mask = '1;
    tick();
    #1;
    check("mask_out_valid", out_valid, 1);
    check("mask_sum", data_out, 60);
    step();
    drain();
`endif

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      data_in   = NP*W'($urandom);
`ifdef C_ADD_NTO1_PIPE_MASK_EN
      port_mask = NP'($urandom);
`endif
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
